// File: rtl/lzx_vend_ctrl_if.sv
// rtl/lzx_vend_ctrl_if.sv - coin/cancel inputs and vend/change outputs of the vending controller
interface lzx_vend_ctrl_if #(
  parameter int CREDIT_W = 4
);
  logic [2:0]          In;
  logic                cancel;
  logic                D_out;
  logic                C;
  logic                busy;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output In, cancel,
    input  D_out, C, busy, coin_rej, credit
  );

  modport slave (
    input  In, cancel,
    output D_out, C, busy, coin_rej, credit
  );
endinterface

// File: rtl/lzx_vend_ctrl.sv
// rtl/lzx_vend_ctrl.sv - coin-accepting vending controller with vend pulse and per-unit change
module lzx_vend_ctrl #(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  lzx_vend_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                d_out_q;
  logic                c_q;
  logic                rej_q, rej_d;

  logic [2:0]          coin_hot;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] coin_sum;
  logic                coin_extra;

  // Pick the single accepted coin (lowest bit wins) and flag any bits that get dropped
  always_comb begin
    coin_hot = 3'b000;
    coin_val = '0;
    if (bus.In[0]) begin
      coin_hot = 3'b001;
      coin_val = CREDIT_W'(1);
    end else if (bus.In[1]) begin
      coin_hot = 3'b010;
      coin_val = CREDIT_W'(2);
    end else if (bus.In[2]) begin
      coin_hot = 3'b100;
      coin_val = CREDIT_W'(4);
    end
    coin_extra = |(bus.In & ~coin_hot);
    coin_sum   = credit_q + coin_val;
  end

  // Next-state, next-credit and reject decision
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = 1'b0;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (state_q == S_ACCUM && bus.cancel) begin
          // Refund everything; a coin in the same cycle is not credited
          state_d = S_CHANGE;
          rej_d   = |bus.In;
        end else if (|bus.In) begin
          credit_d = coin_sum;
          rej_d    = coin_extra;
          state_d  = (coin_sum >= PRICE_C) ? S_VEND : S_ACCUM;
        end
      end
      S_VEND: begin
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q > PRICE_C) ? S_CHANGE : S_IDLE;
        rej_d    = |bus.In;
      end
      S_CHANGE: begin
        // One C cycle per unit: leave once the last unit is being paid out
        credit_d = credit_q - ONE_C;
        state_d  = (credit_q <= ONE_C) ? S_IDLE : S_CHANGE;
        rej_d    = |bus.In;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end
    endcase
  end

  // State, credit and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      d_out_q  <= 1'b0;
      c_q      <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      d_out_q  <= (state_d == S_VEND);
      c_q      <= (state_d == S_CHANGE);
      rej_q    <= rej_d;
    end
  end

  assign bus.D_out    = d_out_q;
  assign bus.C        = c_q;
  assign bus.busy     = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign bus.coin_rej = rej_q;
  assign bus.credit   = credit_q;

endmodule

// File: tb/tb_lzx_vend_ctrl.sv
// tb/tb_lzx_vend_ctrl.sv - directed scoreboard bench for the vending controller
module tb_lzx_vend_ctrl;

  logic clk;
  logic rst_n;

  lzx_vend_ctrl_if #(.CREDIT_W(4)) bus ();

  lzx_vend_ctrl #(.PRICE(4), .CREDIT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  // Observed vector: {D_out, C, busy, coin_rej, credit[3:0]}
  function automatic logic [7:0] observe();
    return {bus.D_out, bus.C, bus.busy, bus.coin_rej, bus.credit};
  endfunction

  function automatic logic [7:0] pack(input logic d, input logic c, input logic b,
                                      input logic r, input int cr);
    return {d, c, b, r, 4'(cr)};
  endfunction

  task automatic check_head();
    exp_t e;
    logic [7:0] obs;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e   = exp_q.pop_front();
    obs = observe();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed D/C/busy/rej/credit=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
             e.tag, obs[7], obs[6], obs[5], obs[4], obs[3:0],
             e.exp[7], e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
    end
    checks++;
    assert (!(bus.D_out === 1'b1 && bus.C === 1'b1)) else begin
      errors++;
      $error("FAIL %s_exclusive observed D_out=%b C=%b expected not both 1", e.tag, bus.D_out, bus.C);
    end
  endtask

  // Drive one cycle of stimulus, push what the outputs must be after the edge, then compare
  task automatic step(input string tag, input logic [2:0] coin, input logic cxl,
                      input logic d, input logic c, input logic b, input logic r, input int cr);
    exp_t e;
    bus.In     = coin;
    bus.cancel = cxl;
    e.tag = tag;
    e.exp = pack(d, c, b, r, cr);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.In     = 3'b000;
    bus.cancel = 1'b0;
    check_head();
  endtask

  initial begin
    exp_t e;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.In     = 3'b000;
    bus.cancel = 1'b0;
    #2;
    e.tag = "reset_state"; e.exp = 8'h00; exp_q.push_back(e);
    check_head();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Four half-unit coins: exact price, no change
    step("a_c1",   3'b001, 0, 0,0,0,0, 1);
    step("a_c2",   3'b001, 0, 0,0,0,0, 2);
    step("a_c3",   3'b001, 0, 0,0,0,0, 3);
    step("a_vend", 3'b001, 0, 1,0,1,0, 4);
    step("a_idle", 3'b000, 0, 0,0,0,0, 0);
    step("a_cxl_idle_ignored", 3'b000, 1, 0,0,0,0, 0);

    // Credit 3 + 2.0 coin: vend then three change pulses; cancel and coin in VEND ignored/rejected
    step("b_c1",   3'b001, 0, 0,0,0,0, 1);
    step("b_c2",   3'b001, 0, 0,0,0,0, 2);
    step("b_c3",   3'b001, 0, 0,0,0,0, 3);
    step("b_vend", 3'b100, 0, 1,0,1,0, 7);
    step("b_ch1",  3'b001, 1, 0,1,1,1, 3);
    step("b_ch2",  3'b000, 0, 0,1,1,0, 2);
    step("b_ch3",  3'b000, 0, 0,1,1,0, 1);
    step("b_idle", 3'b000, 0, 0,0,0,0, 0);

    // Credit 3 + cancel: full refund, no vend
    step("c_c1",   3'b001, 0, 0,0,0,0, 1);
    step("c_c2",   3'b001, 0, 0,0,0,0, 2);
    step("c_c3",   3'b001, 0, 0,0,0,0, 3);
    step("c_ch1",  3'b000, 1, 0,1,1,0, 3);
    step("c_ch2",  3'b000, 0, 0,1,1,0, 2);
    step("c_ch3",  3'b000, 0, 0,1,1,0, 1);
    step("c_idle", 3'b000, 0, 0,0,0,0, 0);

    // Coin during CHANGE: rejected, change count unchanged
    step("d_c1",   3'b001, 0, 0,0,0,0, 1);
    step("d_c2",   3'b010, 0, 0,0,0,0, 3);
    step("d_vend", 3'b100, 0, 1,0,1,0, 7);
    step("d_ch1",  3'b000, 0, 0,1,1,0, 3);
    step("d_ch2",  3'b010, 0, 0,1,1,1, 2);
    step("d_ch3",  3'b000, 0, 0,1,1,0, 1);
    step("d_idle", 3'b000, 0, 0,0,0,0, 0);

    // Two coins at once, then cancel beating a coin
    step("e_multi",  3'b011, 0, 0,0,0,1, 1);
    step("e_c2",     3'b001, 0, 0,0,0,0, 2);
    step("e_cxlcoin",3'b001, 1, 0,1,1,1, 2);
    step("e_ch2",    3'b000, 0, 0,1,1,0, 1);
    step("e_idle",   3'b000, 0, 0,0,0,0, 0);

    // Reset during the second change pulse
    step("f_c1",   3'b001, 0, 0,0,0,0, 1);
    step("f_c2",   3'b001, 0, 0,0,0,0, 2);
    step("f_c3",   3'b001, 0, 0,0,0,0, 3);
    step("f_vend", 3'b100, 0, 1,0,1,0, 7);
    step("f_ch1",  3'b000, 0, 0,1,1,0, 3);
    step("f_ch2",  3'b000, 0, 0,1,1,0, 2);
    rst_n = 1'b0;
    #1;
    e.tag = "f_async_reset"; e.exp = 8'h00; exp_q.push_back(e);
    check_head();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("f_after_rel",  3'b000, 0, 0,0,0,0, 0);
    step("f_first_coin", 3'b010, 0, 0,0,0,0, 2);
    step("f_ch1",        3'b000, 1, 0,1,1,0, 2);
    step("f_ch2",        3'b000, 0, 0,1,1,0, 1);
    step("f_idle",       3'b000, 0, 0,0,0,0, 0);

    // Coin accepted on the very first edge after reset release
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step("g_first_edge", 3'b100, 0, 1,0,1,0, 4);
    step("g_idle",       3'b000, 0, 0,0,0,0, 0);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
